feedback_scorer: RTL and testbench
==================================

Name: feedback_scorer

Overview:
Scores one submitted guess against the secret code for the 4-peg, 3-bit-colour Mastermind game. Consumes the most-recent-guess selection bus produced by the guess-history block and the secret from the code generator. Produces exact (right colour, right slot) and partial (right colour, wrong slot) counts, plus win and game-over flags. Runs a fixed-latency serial compare so duplicate colours are handled correctly without a wide combinational matcher.

Parameters:
COLOR_W, 3, bits per peg colour
MAX_TURNS, 8, number of scored guesses after which the game is over

Ports:
clk  input  1  system clock; all logic on rising edge
reset_n  input  1  synchronous, active-low reset
start  input  1  request to score the current guess; sampled only in IDLE
guess3..guess0  input  COLOR_W each  guess pegs (from history selection outputs)
secret3..secret0  input  COLOR_W each  secret pegs
busy  output  1  high from the cycle after an accepted start until done
done  output  1  one-cycle pulse when results are valid and updated
exact  output  3  exact-match count, 0..4
partial  output  3  colour-only match count, 0..4
win  output  1  sticky; set when a score has exact==4
game_over  output  1  sticky; set on win or when turns_used reaches MAX_TURNS
turns_used  output  4  number of completed scorings, saturates at MAX_TURNS

Behaviour:
- Reset (reset_n==0 at a rising edge): state IDLE; busy=0, done=0, exact=0, partial=0, win=0, game_over=0, turns_used=0; all internal flags cleared. Reset mid-scoring aborts the scoring with no result.
- States: IDLE, EXACT, PARTIAL, REPORT.
- IDLE: if start==1 and game_over==0 at edge T, latch guess3..0 and secret3..0 into internal registers, clear match flags, set busy=1, and go to EXACT. A start while game_over==1 is ignored.
- EXACT, edges T+1..T+4: peg k=0..3, one per cycle. If g[k]==s[k], set gm[k]=sm[k]=1 and increment the exact accumulator.
- PARTIAL, edges T+5..T+20: 16 cycles over (i,j), i-major, i,j = 0..3. The found flag clears at j==0.
  - If !gm[i], !sm[j], !found, and g[i]==s[j]: set sm[j]=1 and found=1, and increment the partial accumulator.
  - Each guess peg claims at most one secret peg, the lowest-index free one.
- REPORT, edge T+21:
  - Load exact/partial from the accumulators.
  - Set done=1 for exactly one cycle and busy=0.
  - Increment turns_used, saturating at MAX_TURNS.
  - Set win if exact==4.
  - Set game_over if win is set or the new turns_used==MAX_TURNS.
  - Return to IDLE.
- Latency: done is high in the cycle after edge T+21, i.e. 21 clocks after the accepting edge. The next start is accepted at T+22 at the earliest.
- exact/partial hold their last values until the next REPORT. They are never partially updated while busy.
- start while busy is ignored, not queued. Input changes after the start edge have no effect on the in-flight scoring.
- Invariant: exact+partial <= 4. The accumulators are 3 bits and never wrap.
- win and game_over clear only on reset.

Test Plan:
- Secret (s3..s0)=3,2,1,0 and guess=3,2,1,0, start pulse -> done exactly 21 clocks later; exact=4, partial=0, win=1, game_over=1, turns_used=1; a further start is ignored (busy stays 0).
- Secret=3,2,1,0, guess=0,1,2,3 -> exact=0, partial=4, win=0.
- Duplicates: secret=1,1,2,2, guess=1,2,1,5 -> exact=1, partial=2. Secret=4,4,4,4, guess=4,5,5,4 -> exact=2, partial=0.
- 8 non-winning scorings (secret=7,7,7,7, guess=0,0,0,0) -> each gives exact=0, partial=0; turns_used counts 1..8; game_over rises with the 8th done; a 9th start is ignored.
- Change the guess and re-pulse start at T+5 -> the re-pulse is ignored; the result reflects the guess latched at T.
- Drive reset_n low at T+10 of a scoring -> no done pulse; all outputs read 0 the next cycle; a new start scores normally.

Source files
------------

// File: rtl/feedback_scorer.sv
// Mastermind scorer: serial exact pass (4 cycles) then partial pass (16 cycles), done 21 clocks after start.
// No backpressure: start is only sampled in IDLE, and starts arriving while busy or after game over are dropped.
module feedback_scorer #(
  parameter int COLOR_W   = 3,
  parameter int MAX_TURNS = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [COLOR_W-1:0] guess3,
  input  logic [COLOR_W-1:0] guess2,
  input  logic [COLOR_W-1:0] guess1,
  input  logic [COLOR_W-1:0] guess0,
  input  logic [COLOR_W-1:0] secret3,
  input  logic [COLOR_W-1:0] secret2,
  input  logic [COLOR_W-1:0] secret1,
  input  logic [COLOR_W-1:0] secret0,
  output logic               busy,
  output logic               done,
  output logic [2:0]         exact,
  output logic [2:0]         partial,
  output logic               win,
  output logic               game_over,
  output logic [3:0]         turns_used
);

  typedef enum logic [1:0] {S_IDLE, S_EXACT, S_PARTIAL, S_REPORT} state_t;

  localparam logic [3:0] MAX_T = 4'(MAX_TURNS);

  state_t state_q, state_d;

  logic [3:0][COLOR_W-1:0] g_q, g_d, s_q, s_d;
  logic [3:0] gm_q, gm_d, sm_q, sm_d;
  logic       found_q, found_d;
  logic [3:0] step_q, step_d;
  logic [2:0] eacc_q, eacc_d, pacc_q, pacc_d;
  logic [2:0] exact_q, exact_d, partial_q, partial_d;
  logic       done_q, done_d, win_q, win_d, go_q, go_d;
  logic [3:0] turns_q, turns_d;
  logic       accept;
  logic       found_now;
  logic [1:0] idx_i, idx_j;

  assign accept = start && !go_q;
  // In PARTIAL the step counter walks (i,j) i-major; in EXACT its low bits are the peg index.
  assign idx_i  = step_q[3:2];
  assign idx_j  = step_q[1:0];

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (accept) state_d = S_EXACT;
      S_EXACT:   if (idx_j == 2'd3) state_d = S_PARTIAL;
      S_PARTIAL: if (step_q == 4'd15) state_d = S_REPORT;
      S_REPORT:  state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    g_d       = g_q;
    s_d       = s_q;
    gm_d      = gm_q;
    sm_d      = sm_q;
    found_d   = found_q;
    step_d    = step_q;
    eacc_d    = eacc_q;
    pacc_d    = pacc_q;
    exact_d   = exact_q;
    partial_d = partial_q;
    done_d    = 1'b0;
    win_d     = win_q;
    go_d      = go_q;
    turns_d   = turns_q;
    found_now = (idx_j == 2'd0) ? 1'b0 : found_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          g_d     = {guess3, guess2, guess1, guess0};
          s_d     = {secret3, secret2, secret1, secret0};
          gm_d    = '0;
          sm_d    = '0;
          found_d = 1'b0;
          step_d  = '0;
          eacc_d  = '0;
          pacc_d  = '0;
        end
      end
      S_EXACT: begin
        if (g_q[idx_j] == s_q[idx_j]) begin
          gm_d[idx_j] = 1'b1;
          sm_d[idx_j] = 1'b1;
          eacc_d      = eacc_q + 3'd1;
        end
        step_d = (idx_j == 2'd3) ? 4'd0 : step_q + 4'd1;
      end
      S_PARTIAL: begin
        found_d = found_now;
        // Lowest free secret peg wins because j scans upward and found blocks later claims.
        if (!gm_q[idx_i] && !sm_q[idx_j] && !found_now && (g_q[idx_i] == s_q[idx_j])) begin
          sm_d[idx_j] = 1'b1;
          found_d     = 1'b1;
          pacc_d      = pacc_q + 3'd1;
        end
        step_d = step_q + 4'd1;
      end
      S_REPORT: begin
        exact_d   = eacc_q;
        partial_d = pacc_q;
        done_d    = 1'b1;
        turns_d   = (turns_q < MAX_T) ? turns_q + 4'd1 : turns_q;
        win_d     = win_q || (eacc_q == 3'd4);
        go_d      = go_q || win_d || (turns_d == MAX_T);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      g_q       <= '0;
      s_q       <= '0;
      gm_q      <= '0;
      sm_q      <= '0;
      found_q   <= 1'b0;
      step_q    <= '0;
      eacc_q    <= '0;
      pacc_q    <= '0;
      exact_q   <= '0;
      partial_q <= '0;
      done_q    <= 1'b0;
      win_q     <= 1'b0;
      go_q      <= 1'b0;
      turns_q   <= '0;
    end else begin
      g_q       <= g_d;
      s_q       <= s_d;
      gm_q      <= gm_d;
      sm_q      <= sm_d;
      found_q   <= found_d;
      step_q    <= step_d;
      eacc_q    <= eacc_d;
      pacc_q    <= pacc_d;
      exact_q   <= exact_d;
      partial_q <= partial_d;
      done_q    <= done_d;
      win_q     <= win_d;
      go_q      <= go_d;
      turns_q   <= turns_d;
    end
  end

  always_comb begin
    busy       = (state_q != S_IDLE);
    done       = done_q;
    exact      = exact_q;
    partial    = partial_q;
    win        = win_q;
    game_over  = go_q;
    turns_used = turns_q;
  end

endmodule

// File: tb/tb_feedback_scorer.sv
// Bench for feedback_scorer: directed table, hand-written corner sequences, randomized games vs a colour-count model.
module tb_feedback_scorer;

  typedef logic [3:0][2:0] pegs_t;
  typedef struct {
    pegs_t g;
    pegs_t s;
    int    e;
    int    p;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [2:0] guess3, guess2, guess1, guess0;
  logic [2:0] secret3, secret2, secret1, secret0;
  logic       busy, done, win, game_over;
  logic [2:0] exact, partial;
  logic [3:0] turns_used;

  int n_cmp = 0;
  int n_bad = 0;
  int m_turns;
  bit m_win, m_go;
  vec_t tbl[6];

  always #5 clk = ~clk;

  feedback_scorer #(.COLOR_W(3), .MAX_TURNS(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .guess3(guess3), .guess2(guess2), .guess1(guess1), .guess0(guess0),
    .secret3(secret3), .secret2(secret2), .secret1(secret1), .secret0(secret0),
    .busy(busy), .done(done), .exact(exact), .partial(partial),
    .win(win), .game_over(game_over), .turns_used(turns_used)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int g3, g2, g1, g0, s3, s2, s1, s0, e, p);
    vec_t v;
    v.g = {3'(g3), 3'(g2), 3'(g1), 3'(g0)};
    v.s = {3'(s3), 3'(s2), 3'(s1), 3'(s0)};
    v.e = e;
    v.p = p;
    return v;
  endfunction

  // Mastermind scoring by colour counts: partial = sum over colours of min(unmatched guess, unmatched secret).
  function automatic void ref_score(input pegs_t g, input pegs_t s, output int e, output int p);
    int cg[8];
    int cs[8];
    for (int c = 0; c < 8; c++) begin cg[c] = 0; cs[c] = 0; end
    e = 0;
    p = 0;
    for (int k = 0; k < 4; k++) begin
      if (g[k] == s[k]) e++;
      else begin cg[g[k]]++; cs[s[k]]++; end
    end
    for (int c = 0; c < 8; c++) p += (cg[c] < cs[c]) ? cg[c] : cs[c];
  endfunction

  function automatic pegs_t rand_pegs(input int maxc);
    pegs_t r;
    for (int k = 0; k < 4; k++) r[k] = 3'($urandom_range(0, maxc));
    return r;
  endfunction

  task automatic drive(input pegs_t g, input pegs_t s);
    {guess3, guess2, guess1, guess0}     = g;
    {secret3, secret2, secret1, secret0} = s;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    start   = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    m_turns = 0;
    m_win   = 1'b0;
    m_go    = 1'b0;
  endtask

  // Scores one guess that must be accepted. scramble: junk inputs/starts while busy.
  // repulse: changed guess plus a start sampled at edge T+5.
  task automatic do_score(input pegs_t g, input pegs_t s, input int exp_e, input int exp_p,
                          input bit scramble, input bit repulse, input string tag);
    int lat;
    int busy_low;
    drive(g, s);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, " busy after start"}, busy, 1);
    lat = 0;
    busy_low = 0;
    while (!done && lat < 40) begin
      if (!busy) busy_low++;
      if (scramble) begin
        drive(rand_pegs(7), rand_pegs(7));
        start = 1'($urandom_range(0, 1));
      end
      if (repulse && lat == 4) begin
        drive(~g, s);
        start = 1'b1;
      end
      if (repulse && lat == 5) start = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    m_turns = (m_turns < 8) ? m_turns + 1 : m_turns;
    if (exp_e == 4) m_win = 1'b1;
    if (m_win || m_turns == 8) m_go = 1'b1;
    check({tag, " latency"}, lat, 21);
    check({tag, " busy low while scoring"}, busy_low, 0);
    check({tag, " busy at done"}, busy, 0);
    check({tag, " exact"}, exact, exp_e);
    check({tag, " partial"}, partial, exp_p);
    check({tag, " win"}, win, m_win);
    check({tag, " game_over"}, game_over, m_go);
    check({tag, " turns_used"}, turns_used, m_turns);
    @(posedge clk); #1;
    check({tag, " done one cycle"}, done, 0);
  endtask

  task automatic try_ignored(input string tag);
    int pulses;
    drive(rand_pegs(7), rand_pegs(7));
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, " busy stays low"}, busy, 0);
    pulses = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done || busy) pulses++;
    end
    check({tag, " no activity"}, pulses, 0);
    check({tag, " turns unchanged"}, turns_used, m_turns);
  endtask

  initial begin
    int e, p, pulses;
    pegs_t g, s;

    tbl[0] = mk(3, 2, 1, 0, 3, 2, 1, 0, 4, 0);
    tbl[1] = mk(0, 1, 2, 3, 3, 2, 1, 0, 0, 4);
    tbl[2] = mk(1, 2, 1, 5, 1, 1, 2, 2, 1, 2);
    tbl[3] = mk(4, 5, 5, 4, 4, 4, 4, 4, 2, 0);
    tbl[4] = mk(0, 0, 0, 0, 7, 7, 7, 7, 0, 0);
    tbl[5] = mk(7, 0, 0, 0, 0, 7, 0, 0, 2, 2);

    reset_n = 1'b0;
    start   = 1'b0;
    drive('0, '0);
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset exact", exact, 0);
    check("reset partial", partial, 0);
    check("reset win", win, 0);
    check("reset game_over", game_over, 0);
    check("reset turns_used", turns_used, 0);
    reset_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      apply_reset();
      do_score(tbl[i].g, tbl[i].s, tbl[i].e, tbl[i].p, 1'b0, 1'b0, $sformatf("tbl%0d", i));
    end

    // A winning score ends the game; the next start must be dropped.
    apply_reset();
    do_score(tbl[0].g, tbl[0].s, 4, 0, 1'b0, 1'b0, "win");
    try_ignored("after win");

    // Eight non-winning turns exhaust the game.
    apply_reset();
    for (int t = 0; t < 8; t++)
      do_score(tbl[4].g, tbl[4].s, 0, 0, 1'b0, 1'b0, $sformatf("turn%0d", t + 1));
    try_ignored("after 8 turns");

    // Start re-pulsed mid-scoring with a different guess: result follows the first guess.
    apply_reset();
    do_score(tbl[0].g, tbl[0].s, 4, 0, 1'b0, 1'b1, "repulse");

    // Reset at T+10 aborts scoring and clears earlier results.
    apply_reset();
    do_score(tbl[1].g, tbl[1].s, 0, 4, 1'b0, 1'b0, "pre-abort");
    drive(tbl[2].g, tbl[2].s);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    m_turns = 0;
    m_win   = 1'b0;
    m_go    = 1'b0;
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort exact", exact, 0);
    check("abort partial", partial, 0);
    check("abort win", win, 0);
    check("abort game_over", game_over, 0);
    check("abort turns_used", turns_used, 0);
    pulses = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    check("abort no done", pulses, 0);
    do_score(tbl[2].g, tbl[2].s, 1, 2, 1'b0, 1'b0, "post-abort");

    // Randomized games, restarting whenever the model says the game is over.
    apply_reset();
    for (int n = 0; n < 120; n++) begin
      if (m_go) begin
        if ($urandom_range(0, 1) == 1) try_ignored($sformatf("rnd%0d over", n));
        apply_reset();
      end
      s = rand_pegs(($urandom_range(0, 1) == 1) ? 3 : 7);
      case ($urandom_range(0, 3))
        0:       g = s;
        1:       g = {s[0], s[3], s[2], s[1]};
        default: g = rand_pegs(($urandom_range(0, 1) == 1) ? 3 : 7);
      endcase
      ref_score(g, s, e, p);
      do_score(g, s, e, p, 1'($urandom_range(0, 1)), 1'b0, $sformatf("rnd%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
